elixirchip_es1_spu_op_logic: RTL and testbench

ELIXIRCHIP_ES1_SPU_OP_LOGIC -- requirements
Module: elixirchip_es1_spu_op_logic

---
 rtl/elixirchip_es1_spu_pkg.sv | 19 +
 rtl/elixirchip_es1_spu_op_logic_if.sv | 42 ++++
 rtl/elixirchip_es1_spu_logic_lane.sv | 57 +++++
 rtl/elixirchip_es1_spu_op_logic.sv | 100 ++++++++++
 tb/tb_elixirchip_es1_spu_op_logic.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU definitions: logic-unit opcode encoding.
// No ports; imported by the SPU logic files.
package elixirchip_es1_spu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_ORN  = 3'd7
    } op_t;

    localparam int unsigned MIN_LATENCY = 1;
    localparam int unsigned MAX_LATENCY = 4;

endpackage

// File: rtl/elixirchip_es1_spu_op_logic_if.sv
// Operand/result bundle of the SPU logic unit.
// slave: s_* in, m_* out (DUT side); master: the opposite side.
interface elixirchip_es1_spu_op_logic_if
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int NUM_LANES = 1
);
    localparam int LW = NUM_LANES * DATA_BITS;

    op_t           s_op;
    logic          s_acc;
    logic [LW-1:0] s_data0;
    logic [LW-1:0] s_data1;
    logic          s_clear;
    logic          s_valid;
    logic [LW-1:0] m_data;
    logic          m_valid;

    modport slave (
        input  s_op,
        input  s_acc,
        input  s_data0,
        input  s_data1,
        input  s_clear,
        input  s_valid,
        output m_data,
        output m_valid
    );

    modport master (
        output s_op,
        output s_acc,
        output s_data0,
        output s_data1,
        output s_clear,
        output s_valid,
        input  m_data,
        input  m_valid
    );

endinterface

// File: rtl/elixirchip_es1_spu_logic_lane.sv
// Final-stage logic lane: op(a,b) into a result register.
// Ports: clk/reset/cke, op/acc/clear/valid, a_in/b operands, data result.
module elixirchip_es1_spu_logic_lane
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLEAR_DATA = 0
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  op_t                  op,
    input  logic                 acc,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] a_in,
    input  logic [DATA_BITS-1:0] b,
    output logic [DATA_BITS-1:0] data
);

    localparam logic [DATA_BITS-1:0] CLEAR_VAL =
        DATA_BITS'(CLEAR_DATA);

    logic [DATA_BITS-1:0] a;
    logic [DATA_BITS-1:0] res;

    // Accumulate reads the result register directly, so
    // consecutive acc inputs chain without a bypass path.
    always_comb begin
        a   = acc ? data : a_in;
        res = '0;
        unique case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_ANDN: res = a & ~b;
            OP_ORN:  res = a | ~b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= CLEAR_VAL;
        end else if (cke) begin
            if (clear) begin
                data <= CLEAR_VAL;
            end else if (valid) begin
                data <= res;
            end
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_logic.sv
// SPU bitwise logic unit: LATENCY-1 input stages, then per-lane op.
// Ports: clk, reset (sync, high), cke, bus (slave: s_* in, m_* out).
module elixirchip_es1_spu_op_logic
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter int    NUM_LANES  = 1,
    parameter int    CLEAR_DATA = 0,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
)
(
    input  logic clk,
    input  logic reset,
    input  logic cke,
    elixirchip_es1_spu_op_logic_if.slave bus
);

    localparam int LW = NUM_LANES * DATA_BITS;

    typedef struct packed {
        op_t           op;
        logic          acc;
        logic          clear;
        logic          valid;
        logic [LW-1:0] d0;
        logic [LW-1:0] d1;
    } stg_t;

    stg_t          s_in;
    stg_t          d_in;
    logic [LW-1:0] m_data_w;
    logic          m_valid_q;

    assign s_in = '{
        op:    bus.s_op,
        acc:   bus.s_acc,
        clear: bus.s_clear,
        valid: bus.s_valid,
        d0:    bus.s_data0,
        d1:    bus.s_data1
    };

    if (LATENCY <= 1) begin : g_nodly
        assign d_in = s_in;
    end else begin : g_dly
        stg_t stg [LATENCY-1];

        // Only control bits need reset; stale operands are
        // harmless once valid/clear are low.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < LATENCY-1; i++) begin
                    stg[i].acc   <= 1'b0;
                    stg[i].clear <= 1'b0;
                    stg[i].valid <= 1'b0;
                end
            end else if (cke) begin
                stg[0] <= s_in;
                for (int i = 1; i < LATENCY-1; i++) begin
                    stg[i] <= stg[i-1];
                end
            end
        end

        assign d_in = stg[LATENCY-2];
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        elixirchip_es1_spu_logic_lane #(
            .DATA_BITS  (DATA_BITS),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .cke   (cke),
            .op    (d_in.op),
            .acc   (d_in.acc),
            .clear (d_in.clear),
            .valid (d_in.valid),
            .a_in  (d_in.d0[k*DATA_BITS +: DATA_BITS]),
            .b     (d_in.d1[k*DATA_BITS +: DATA_BITS]),
            .data  (m_data_w[k*DATA_BITS +: DATA_BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
        end else if (cke) begin
            m_valid_q <= d_in.valid | d_in.clear;
        end
    end

    assign bus.m_data  = m_data_w;
    assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// Bench for elixirchip_es1_spu_op_logic: two configs, scoreboard.
// A: LATENCY 3, 2 lanes, CLEAR 123; B: LATENCY 1, 1 lane, CLEAR 0.
module tb_elixirchip_es1_spu_op_logic;
    import elixirchip_es1_spu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic cke;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_logic_if #(
        .DATA_BITS(8), .NUM_LANES(2)) mif_a ();
    elixirchip_es1_spu_op_logic_if #(
        .DATA_BITS(8), .NUM_LANES(1)) mif_b ();

    elixirchip_es1_spu_op_logic #(
        .LATENCY(3), .DATA_BITS(8), .NUM_LANES(2),
        .CLEAR_DATA(123)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .cke   (cke),
        .bus   (mif_a.slave)
    );

    elixirchip_es1_spu_op_logic #(
        .LATENCY(1), .DATA_BITS(8), .NUM_LANES(1),
        .CLEAR_DATA(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .cke   (cke),
        .bus   (mif_b.slave)
    );

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   checks = 0;
    int   passes = 0;
    int   ecnt   = 0;
    bit   last_en = 1'b0;

    always @(posedge clk) begin
        if (cke) ecnt <= ecnt + 1;
        last_en <= cke && !reset;
    end

    a_rst_clears_valid: assert property (
        @(posedge clk) reset |=> !mif_a.m_valid);

    always @(negedge clk) begin
        if (last_en && mif_a.m_valid) begin
            checks++;
            if (qa.size() == 0) begin
                $display("FAIL a_unexpected: got %h, required none",
                         mif_a.m_data);
            end else begin
                ea = qa.pop_front();
                if (mif_a.m_data === ea.d && ecnt == ea.due)
                    passes++;
                else
                    $display("FAIL a_result: got %h @%0d, required %h @%0d",
                             mif_a.m_data, ecnt, ea.d, ea.due);
            end
        end
    end

    always @(negedge clk) begin
        if (last_en && mif_b.m_valid) begin
            checks++;
            if (qb.size() == 0) begin
                $display("FAIL b_unexpected: got %h, required none",
                         mif_b.m_data);
            end else begin
                eb = qb.pop_front();
                if (mif_b.m_data === eb.d[7:0] && ecnt == eb.due)
                    passes++;
                else
                    $display("FAIL b_result: got %h @%0d, required %h @%0d",
                             mif_b.m_data, ecnt, eb.d[7:0], eb.due);
            end
        end
    end

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input op_t op, input bit acc,
                         input bit clr, input bit vld,
                         input logic [15:0] d0,
                         input logic [15:0] d1,
                         input logic [15:0] e, input bit push);
        mif_a.s_op    = op;
        mif_a.s_acc   = acc;
        mif_a.s_clear = clr;
        mif_a.s_valid = vld;
        mif_a.s_data0 = d0;
        mif_a.s_data1 = d1;
        if (push && (vld || clr)) qa.push_back('{e, ecnt + 3});
    endtask

    task automatic drive_a(input op_t op, input bit acc,
                           input bit clr, input bit vld,
                           input logic [15:0] d0,
                           input logic [15:0] d1,
                           input logic [15:0] e, input bit push);
        set_a(op, acc, clr, vld, d0, d1, e, push);
        step();
    endtask

    task automatic drive_b(input op_t op, input bit acc,
                           input bit clr, input bit vld,
                           input logic [7:0] d0,
                           input logic [7:0] d1,
                           input logic [7:0] e);
        mif_b.s_op    = op;
        mif_b.s_acc   = acc;
        mif_b.s_clear = clr;
        mif_b.s_valid = vld;
        mif_b.s_data0 = d0;
        mif_b.s_data1 = d1;
        if (vld || clr) qb.push_back('{{8'h00, e}, ecnt + 1});
        step();
    endtask

    task automatic idle(input int n);
        mif_a.s_valid = 1'b0;
        mif_a.s_clear = 1'b0;
        mif_a.s_acc   = 1'b0;
        mif_b.s_valid = 1'b0;
        mif_b.s_clear = 1'b0;
        mif_b.s_acc   = 1'b0;
        repeat (n) step();
    endtask

    logic [15:0] sd;
    logic        sv;

    initial begin
        reset = 1'b1;
        cke   = 1'b0;
        mif_a.s_op = OP_AND;
        mif_a.s_data0 = '0;
        mif_a.s_data1 = '0;
        mif_b.s_op = OP_AND;
        mif_b.s_data0 = '0;
        mif_b.s_data1 = '0;
        idle(3);
        chk("reset_a_data", mif_a.m_data, 16'h7b7b);
        chk("reset_a_valid", {15'd0, mif_a.m_valid}, 16'd0);
        chk("reset_b_data", {8'd0, mif_b.m_data}, 16'd0);
        reset = 1'b0;
        cke   = 1'b1;
        idle(1);

        drive_a(OP_NAND, 0, 0, 1, 16'hff5a, 16'h0fa5, 16'hf0ff, 1);
        drive_a(OP_ANDN, 0, 0, 1, 16'haaf0, 16'h0f3c, 16'ha0c0, 1);
        drive_a(OP_ORN,  0, 0, 1, 16'h8000, 16'hfff0, 16'h800f, 1);
        drive_a(OP_XNOR, 0, 0, 1, 16'h0f22, 16'hf023, 16'h00fe, 1);

        sd = mif_a.m_data;
        sv = mif_a.m_valid;
        set_a(OP_AND, 0, 0, 1, 16'h12cc, 16'hffaa, 16'h1288, 1);
        cke = 1'b0;
        repeat (2) begin
            step();
            chk("freeze_data", mif_a.m_data, sd);
            chk("freeze_valid", {15'd0, mif_a.m_valid}, {15'd0, sv});
        end
        cke = 1'b1;
        step();

        drive_a(OP_OR,  0, 0, 1, 16'h010c, 16'h8030, 16'h813c, 1);
        drive_a(OP_XOR, 0, 0, 1, 16'h55ff, 16'h550f, 16'h00f0, 1);
        drive_a(OP_NOR, 0, 0, 1, 16'h0010, 16'h0001, 16'hffee, 1);

        drive_a(OP_AND, 0, 1, 1, 16'hffff, 16'hffff, 16'h7b7b, 1);
        idle(5);
        chk("post_clear_data", mif_a.m_data, 16'h7b7b);
        chk("post_clear_valid", {15'd0, mif_a.m_valid}, 16'd0);

        drive_a(OP_OR,  1, 0, 1, 16'h5555, 16'h0480, 16'h7ffb, 1);
        drive_a(OP_AND, 1, 0, 1, 16'h5555, 16'hf00f, 16'h700b, 1);
        idle(1);

        drive_b(OP_AND, 0, 0, 1, 8'hff, 8'hff, 8'hff);
        drive_b(OP_XOR, 0, 1, 1, 8'haa, 8'h55, 8'h00);
        drive_b(OP_XOR, 1, 0, 1, 8'haa, 8'h01, 8'h01);
        drive_b(OP_XOR, 1, 0, 1, 8'haa, 8'h02, 8'h03);
        drive_b(OP_XOR, 1, 0, 1, 8'haa, 8'h04, 8'h07);
        drive_b(OP_OR,  1, 1, 1, 8'haa, 8'hff, 8'h00);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            idle(1);
        end
        chk("drain", 16'(qa.size() + qb.size()), 16'd0);

        drive_a(OP_XOR, 0, 0, 1, 16'h1234, 16'h00ff, 16'h0, 0);
        drive_a(OP_XOR, 0, 0, 1, 16'h5678, 16'hff00, 16'h0, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(6);
        chk("rst_inflight_data", mif_a.m_data, 16'h7b7b);
        chk("rst_inflight_valid", {15'd0, mif_a.m_valid}, 16'd0);

        idle(2);
        chk("queue_empty", 16'(qa.size() + qb.size()), 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
